// File: rtl/fifo_rd_packer_if.sv
// Read-side bundle of the packer: FIFO pop handshake plus the packed valid/ready output.
// The packer uses the master view; whatever feeds the FIFO data and consumes words uses slave.
interface fifo_rd_packer_if #(
  parameter int DATA_WIDTH = 8,
  parameter int PACK_RATIO = 4
);
  logic                             fifo_empty;
  logic                             fifo_rd_en;
  logic [DATA_WIDTH-1:0]            fifo_rd_data;
  logic                             flush;
  logic                             out_valid;
  logic                             out_ready;
  logic [DATA_WIDTH*PACK_RATIO-1:0] out_data;
  logic [PACK_RATIO-1:0]            out_keep;
  logic                             out_last;

  modport master (
    input  fifo_empty, fifo_rd_data, flush, out_ready,
    output fifo_rd_en, out_valid, out_data, out_keep, out_last
  );

  modport slave (
    output fifo_empty, fifo_rd_data, flush, out_ready,
    input  fifo_rd_en, out_valid, out_data, out_keep, out_last
  );
endinterface

// File: rtl/fifo_rd_packer.sv
// Pops FIFO entries in the rd_clk domain and packs PACK_RATIO of them little-endian
// into one wide word; a flush pulse emits a partial word with a lane mask and last flag.
module fifo_rd_packer #(
  parameter int DATA_WIDTH = 8,
  parameter int PACK_RATIO = 4
) (
  input  logic             rd_clk,
  input  logic             rst,
  fifo_rd_packer_if.master bus
);
  localparam int OUT_WIDTH = DATA_WIDTH * PACK_RATIO;
  localparam int CNT_W     = $clog2(PACK_RATIO + 1);

  logic [OUT_WIDTH-1:0]  pack;
  logic [CNT_W-1:0]      fill_cnt;
  logic                  inflight;
  logic                  flush_pending;

  logic                  out_valid_q;
  logic [OUT_WIDTH-1:0]  out_data_q;
  logic [PACK_RATIO-1:0] out_keep_q;
  logic                  out_last_q;

  logic                  rd_en;
  logic                  out_free;
  logic                  full;
  logic                  do_full;
  logic                  do_partial;
  logic                  do_drop;
  logic [PACK_RATIO-1:0] part_keep;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    out_free   = !out_valid_q || bus.out_ready;
    full       = (fill_cnt == CNT_W'(PACK_RATIO));
    // Count the in-flight entry so the pack register can never be overfilled.
    rd_en      = !rst && !bus.fifo_empty && !flush_pending &&
                 (({1'b0, fill_cnt} + (CNT_W+1)'(inflight)) < (CNT_W+1)'(PACK_RATIO));
    do_full    = full && out_free;
    do_partial = flush_pending && !inflight && out_free && !full && (fill_cnt != '0);
    do_drop    = flush_pending && !inflight && out_free && (fill_cnt == '0);
    part_keep  = '0;
    for (int k = 0; k < PACK_RATIO; k++) begin
      part_keep[k] = (CNT_W'(k) < fill_cnt);
    end
  end

  assign bus.fifo_rd_en = rd_en;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_data   = out_data_q;
  assign bus.out_keep   = out_keep_q;
  assign bus.out_last   = out_last_q;

  // NOTE: sequential state uses non-blocking assignments only, so every read sees pre-edge values.
  always_ff @(posedge rd_clk) begin
    if (rst) begin
      pack          <= '0;
      fill_cnt      <= '0;
      inflight      <= 1'b0;
      flush_pending <= 1'b0;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      out_keep_q    <= '0;
      out_last_q    <= 1'b0;
    end else begin
      inflight <= rd_en;

      // Landing and transfer are mutually exclusive: landing implies fill_cnt < PACK_RATIO
      // and a partial emit requires inflight == 0.
      if (inflight) begin
        for (int k = 0; k < PACK_RATIO; k++) begin
          if (fill_cnt == CNT_W'(k)) pack[k*DATA_WIDTH +: DATA_WIDTH] <= bus.fifo_rd_data;
        end
        fill_cnt <= fill_cnt + CNT_W'(1);
      end

      if (do_full || do_partial) begin
        out_valid_q <= 1'b1;
        out_data_q  <= pack;
        out_keep_q  <= do_full ? {PACK_RATIO{1'b1}} : part_keep;
        out_last_q  <= do_full ? flush_pending : 1'b1;
        fill_cnt    <= '0;
        pack        <= '0;
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end

      // A new flush is only taken while idle; a pending one retires with the word it produced.
      if (flush_pending) flush_pending <= !(do_full || do_partial || do_drop);
      else               flush_pending <= bus.flush;
    end
  end
endmodule

// File: tb/tb_fifo_rd_packer.sv
// Directed bench for fifo_rd_packer: a small array-backed FIFO model feeds the packer
// and each step compares the packed output against hand-computed words.
module tb_fifo_rd_packer;
  logic rd_clk = 1'b0;
  logic rst    = 1'b1;

  fifo_rd_packer_if #(.DATA_WIDTH(8), .PACK_RATIO(4)) bus ();

  fifo_rd_packer #(.DATA_WIDTH(8), .PACK_RATIO(4)) dut (
    .rd_clk (rd_clk),
    .rst    (rst),
    .bus    (bus)
  );

  always #5 rd_clk = ~rd_clk;

  // FIFO model: data appears the cycle after an accepted pop.
  logic [7:0]  mem [256];
  int unsigned wr_ptr = 0;
  int unsigned rd_ptr = 0;

  assign bus.fifo_empty = (wr_ptr == rd_ptr);

  initial bus.fifo_rd_data = '0;
  always @(posedge rd_clk) begin
    if (bus.fifo_rd_en) begin
      bus.fifo_rd_data <= mem[rd_ptr[7:0]];
      rd_ptr           <= rd_ptr + 1;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    mem[wr_ptr[7:0]] = b;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic wait_valid(input string tag, input int limit, output int waited);
    waited = 0;
    while (bus.out_valid !== 1'b1 && waited < limit) begin
      @(negedge rd_clk);
      waited++;
    end
    check({tag, "_seen"}, 32'(bus.out_valid), 32'h1);
  endtask

  int          waited;
  int unsigned base;

  initial begin
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;

    // Reset state
    repeat (3) @(negedge rd_clk);
    check("rst_valid", 32'(bus.out_valid), 32'h0);
    check("rst_data",  bus.out_data, 32'h0);
    check("rst_keep",  32'(bus.out_keep), 32'h0);
    check("rst_last",  32'(bus.out_last), 32'h0);
    check("rst_rd_en", 32'(bus.fifo_rd_en), 32'h0);
    rst = 1'b0;

    // 1: one full word, single-cycle valid, fixed latency
    bus.out_ready = 1'b1;
    push(8'hAA); push(8'hBB); push(8'hCC); push(8'hDD);
    wait_valid("t1", 20, waited);
    check("t1_latency", 32'(waited), 32'd6);
    check("t1_data", bus.out_data, 32'hDDCCBBAA);
    check("t1_keep", 32'(bus.out_keep), 32'hF);
    check("t1_last", 32'(bus.out_last), 32'h0);
    @(negedge rd_clk);
    check("t1_valid_drop", 32'(bus.out_valid), 32'h0);

    // 2: backpressure, stall after two words' worth of pops, back-to-back release
    bus.out_ready = 1'b0;
    base = rd_ptr;
    for (int i = 1; i <= 12; i++) push(8'(i));
    repeat (10) @(negedge rd_clk);
    check("t2_hold_valid", 32'(bus.out_valid), 32'h1);
    check("t2_hold_data0", bus.out_data, 32'h04030201);
    repeat (20) @(negedge rd_clk);
    check("t2_hold_data1", bus.out_data, 32'h04030201);
    check("t2_hold_keep", 32'(bus.out_keep), 32'hF);
    check("t2_pops", rd_ptr - base, 32'd8);
    check("t2_rd_en_stall", 32'(bus.fifo_rd_en), 32'h0);
    check("t2_fifo_nonempty", 32'(bus.fifo_empty), 32'h0);
    bus.out_ready = 1'b1;
    @(negedge rd_clk);
    check("t2_b2b_valid", 32'(bus.out_valid), 32'h1);
    check("t2_b2b_data", bus.out_data, 32'h08070605);
    @(negedge rd_clk);
    check("t2_gap_valid", 32'(bus.out_valid), 32'h0);
    wait_valid("t2_w3", 20, waited);
    check("t2_w3_data", bus.out_data, 32'h0C0B0A09);
    check("t2_w3_last", 32'(bus.out_last), 32'h0);
    @(negedge rd_clk);
    check("t2_drained", 32'(bus.out_valid), 32'h0);

    // 3: partial word on flush
    push(8'hDD); push(8'hEE);
    repeat (5) @(negedge rd_clk);
    bus.flush = 1'b1;
    @(negedge rd_clk);
    bus.flush = 1'b0;
    check("t3_pending", 32'(dut.flush_pending), 32'h1);
    wait_valid("t3", 10, waited);
    check("t3_data", bus.out_data, 32'h0000EEDD);
    check("t3_keep", 32'(bus.out_keep), 32'h3);
    check("t3_last", 32'(bus.out_last), 32'h1);
    check("t3_pending_clr", 32'(dut.flush_pending), 32'h0);
    @(negedge rd_clk);
    check("t3_valid_drop", 32'(bus.out_valid), 32'h0);

    // 4: flush with nothing to emit, then a normal word
    bus.flush = 1'b1;
    @(negedge rd_clk);
    bus.flush = 1'b0;
    check("t4_pending", 32'(dut.flush_pending), 32'h1);
    @(negedge rd_clk);
    check("t4_pending_clr", 32'(dut.flush_pending), 32'h0);
    check("t4_no_valid", 32'(bus.out_valid), 32'h0);
    push(8'h41); push(8'h42); push(8'h43); push(8'h44);
    wait_valid("t4", 20, waited);
    check("t4_data", bus.out_data, 32'h44434241);
    check("t4_last", 32'(bus.out_last), 32'h0);
    @(negedge rd_clk);

    // 5: reset mid-word discards the partial word
    push(8'h11); push(8'h22); push(8'h33);
    repeat (6) @(negedge rd_clk);
    check("t5_no_valid", 32'(bus.out_valid), 32'h0);
    rst = 1'b1;
    push(8'h44); push(8'h55); push(8'h66); push(8'h77);
    #1;
    check("t5_rd_en_rst", 32'(bus.fifo_rd_en), 32'h0);
    @(negedge rd_clk);
    check("t5_fill_clr", 32'(dut.fill_cnt), 32'h0);
    rst = 1'b0;
    wait_valid("t5", 20, waited);
    check("t5_data", bus.out_data, 32'h77665544);
    check("t5_keep", 32'(bus.out_keep), 32'hF);
    @(negedge rd_clk);

    // 6: empty FIFO with flush and out_ready toggling
    for (int i = 0; i < 50; i++) begin
      @(negedge rd_clk);
      bus.flush     = (i % 5 == 0);
      bus.out_ready = i[0];
      #1;
      check("t6_rd_en", 32'(bus.fifo_rd_en), 32'h0);
      check("t6_valid", 32'(bus.out_valid), 32'h0);
    end
    bus.flush = 1'b0;
    @(negedge rd_clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
